// File: rtl/spi_cmd_regfile.sv
// Command decoder and 8-bit register bank behind the SPI slave byte receiver; optional SPI_CMD_AUTOINC_EN.
// Latency: register write / Reg_Wr_Strobe and Tx_Byte / Tx_Byte_Load appear 1 cycle after Rx_Byte_Valid.
// Backpressure: none; every byte strobe is consumed immediately (upstream spaces bytes >= 2 cycles apart).
module spi_cmd_regfile #(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] DEVICE_ID = 8'hE5
) (
  input  logic                  MClk,
  input  logic                  USPI_Rst_N,
  input  logic                  Msg_Start,
  input  logic                  Msg_End,
  input  logic [7:0]            Rx_Byte,
  input  logic                  Rx_Byte_Valid,
  output logic [7:0]            Tx_Byte,
  output logic                  Tx_Byte_Load,
  output logic [NUM_REGS*8-1:0] Ctrl_Regs,
  output logic                  Reg_Wr_Strobe,
  output logic [6:0]            Reg_Wr_Addr,
  output logic [7:0]            Err_Count
);

  typedef enum logic [2:0] {IDLE, CMD, WR, RD, DISCARD} state_t;

  localparam logic [7:0] NREGS_8 = 8'(NUM_REGS);
`ifdef SPI_CMD_AUTOINC_EN
  localparam logic [6:0] LAST_PTR = 7'(NUM_REGS - 1);
`endif

  state_t     state_q, state_d;
  logic [6:0] ptr_q, ptr_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_load_q, tx_load_d;
  logic       wr_stb_q, wr_stb_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] err_q, err_d;

  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       cmd_bad;
  logic       err_inc;

  // Pointer step after a data byte: wrap over the bank, or hold on A when auto-increment is off.
  function automatic logic [6:0] next_ptr(input logic [6:0] p);
`ifdef SPI_CMD_AUTOINC_EN
    return (p == LAST_PTR) ? 7'd0 : p + 7'd1;
`else
    return p;
`endif
  endfunction

  // Read mux: the command byte addresses directly, later bytes use the running pointer.
  always_comb begin
    rd_addr = (state_q == CMD) ? Rx_Byte[6:0] : ptr_q;
    rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 7'(i)) rd_data = regs_q[i];
    end
    cmd_bad = ({1'b0, Rx_Byte[6:0]} >= NREGS_8);
  end

  // Next-state, register-bank update and output pulses.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    regs_d    = regs_q;
    tx_byte_d = tx_byte_q;
    tx_load_d = 1'b0;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    err_inc   = 1'b0;

    if (Msg_Start) begin
      // A new chip-select frame abandons whatever was in progress without penalty.
      state_d = CMD;
    end else begin
      if (Rx_Byte_Valid) begin
        case (state_q)
          CMD: begin
            if (cmd_bad) begin
              state_d = DISCARD;
              err_inc = 1'b1;
            end else if (Rx_Byte[7]) begin
              state_d   = RD;
              tx_byte_d = rd_data;
              tx_load_d = 1'b1;
              ptr_d     = next_ptr(Rx_Byte[6:0]);
            end else begin
              state_d = WR;
              ptr_d   = Rx_Byte[6:0];
            end
          end
          WR: begin
            if (ptr_q == 7'd0) begin
              // Register 0 is the read-only device ID; the write counts as an error.
              err_inc = 1'b1;
            end else begin
              for (int i = 1; i < NUM_REGS; i++) begin
                if (ptr_q == 7'(i)) regs_d[i] = Rx_Byte;
              end
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
            end
            ptr_d = next_ptr(ptr_q);
          end
          RD: begin
            tx_byte_d = rd_data;
            tx_load_d = 1'b1;
            ptr_d     = next_ptr(ptr_q);
          end
          default: ;
        endcase
      end
      // The byte arriving with Msg_End is handled above before the frame closes.
      if (Msg_End) state_d = IDLE;
    end

    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  // State and datapath registers; register 0 resets to the device ID and is never written.
  always_ff @(posedge MClk or negedge USPI_Rst_N) begin
    if (!USPI_Rst_N) begin
      state_q   <= IDLE;
      ptr_q     <= 7'd0;
      tx_byte_q <= 8'h00;
      tx_load_q <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 7'd0;
      err_q     <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? DEVICE_ID : 8'h00;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tx_byte_q <= tx_byte_d;
      tx_load_q <= tx_load_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
      regs_q    <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_ctrl
    assign Ctrl_Regs[8*k +: 8] = regs_q[k];
  end

  assign Tx_Byte       = tx_byte_q;
  assign Tx_Byte_Load  = tx_load_q;
  assign Reg_Wr_Strobe = wr_stb_q;
  assign Reg_Wr_Addr   = wr_addr_q;
  assign Err_Count     = err_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Randomized bench for spi_cmd_regfile with a message-level reference model and output scoreboard.
// Expected Tx bytes and register writes are queued at stimulus time and popped by a monitor.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_spi_cmd_regfile;

  localparam int N = 16;
  localparam logic [7:0] DEV_ID = 8'hE5;

  logic         MClk = 1'b0;
  logic         USPI_Rst_N = 1'b0;
  logic         Msg_Start = 1'b0;
  logic         Msg_End = 1'b0;
  logic [7:0]   Rx_Byte = 8'h00;
  logic         Rx_Byte_Valid = 1'b0;
  logic [7:0]   Tx_Byte;
  logic         Tx_Byte_Load;
  logic [N*8-1:0] Ctrl_Regs;
  logic         Reg_Wr_Strobe;
  logic [6:0]   Reg_Wr_Addr;
  logic [7:0]   Err_Count;

  spi_cmd_regfile #(.NUM_REGS(N), .DEVICE_ID(DEV_ID)) dut (
    .MClk(MClk), .USPI_Rst_N(USPI_Rst_N), .Msg_Start(Msg_Start), .Msg_End(Msg_End),
    .Rx_Byte(Rx_Byte), .Rx_Byte_Valid(Rx_Byte_Valid), .Tx_Byte(Tx_Byte),
    .Tx_Byte_Load(Tx_Byte_Load), .Ctrl_Regs(Ctrl_Regs), .Reg_Wr_Strobe(Reg_Wr_Strobe),
    .Reg_Wr_Addr(Reg_Wr_Addr), .Err_Count(Err_Count)
  );

  always #10 MClk = ~MClk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (message level) ----------------
  logic [7:0]  mreg [N];
  int          m_err;
  int          m_last_wa;
  logic [7:0]  m_last_tx;
  bit          m_active;
  int          m_nbytes;
  int          m_kind;      // 0 write, 1 read, 2 discard
  int          m_ptr;
  logic [7:0]  tx_q [$];
  logic [14:0] wr_q [$];

  function automatic int adv(input int p);
`ifdef SPI_CMD_AUTOINC_EN
    return (p == N - 1) ? 0 : p + 1;
`else
    return p;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mreg[i] = (i == 0) ? DEV_ID : 8'h00;
    m_err = 0; m_last_wa = 0; m_last_tx = 8'h00; m_active = 0; m_nbytes = 0;
    m_kind = 2; m_ptr = 0;
    tx_q.delete(); wr_q.delete();
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_start();
    m_active = 1; m_nbytes = 0;
  endtask

  task automatic model_end();
    m_active = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int a;
    if (!m_active) return;
    if (m_nbytes == 0) begin
      a = int'(b[6:0]);
      if (a >= N) begin
        m_kind = 2; bump_err();
      end else if (b[7]) begin
        m_kind = 1; m_last_tx = mreg[a]; tx_q.push_back(mreg[a]); m_ptr = adv(a);
      end else begin
        m_kind = 0; m_ptr = a;
      end
    end else if (m_kind == 0) begin
      if (m_ptr == 0) bump_err();
      else begin
        mreg[m_ptr] = b; m_last_wa = m_ptr; wr_q.push_back({7'(m_ptr), b});
      end
      m_ptr = adv(m_ptr);
    end else if (m_kind == 1) begin
      m_last_tx = mreg[m_ptr]; tx_q.push_back(mreg[m_ptr]); m_ptr = adv(m_ptr);
    end
    m_nbytes++;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_load = 1'b0;
  logic [7:0]  mon_e;
  logic [14:0] mon_w;

  always @(negedge MClk) begin
    if (USPI_Rst_N) begin
      if (Tx_Byte_Load) begin
        if (prev_load) chk("tx_load_back2back", 32'(prev_load), 32'd0);
        if (tx_q.size() == 0) chk("tx_unexpected", 32'(Tx_Byte_Load), 32'd0);
        else begin
          mon_e = tx_q.pop_front();
          chk("tx_byte", 32'(Tx_Byte), 32'(mon_e));
        end
      end
      if (Reg_Wr_Strobe) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 32'(Reg_Wr_Strobe), 32'd0);
        else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", 32'(Reg_Wr_Addr), 32'(mon_w[14:8]));
          chk("wr_data", 32'(Ctrl_Regs[int'(mon_w[14:8])*8 +: 8]), 32'(mon_w[7:0]));
        end
      end
      prev_load = Tx_Byte_Load;
    end else begin
      prev_load = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge MClk); #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic start_msg();
    Msg_Start = 1'b1; model_start(); tick(); Msg_Start = 1'b0; gap();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_end);
    Rx_Byte = b; Rx_Byte_Valid = 1'b1; Msg_End = with_end;
    model_byte(b);
    if (with_end) model_end();
    tick();
    Rx_Byte_Valid = 1'b0; Msg_End = 1'b0; Rx_Byte = 8'($urandom);
    gap();
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_err_count"}, 32'(Err_Count), 32'(m_err));
    chk({tag, "_wr_addr"}, 32'(Reg_Wr_Addr), 32'(m_last_wa));
    chk({tag, "_tx_byte"}, 32'(Tx_Byte), 32'(m_last_tx));
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_reg%0d", tag, i), 32'(Ctrl_Regs[8*i +: 8]), 32'(mreg[i]));
    chk({tag, "_tx_pending"}, 32'(tx_q.size()), 32'd0);
    chk({tag, "_wr_pending"}, 32'(wr_q.size()), 32'd0);
  endtask

  task automatic end_msg(input string tag);
    Msg_End = 1'b1; model_end(); tick(); Msg_End = 1'b0; tick(); tick();
    check_state(tag);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  nd;
    bit  comb, abandon;
    logic [7:0] cmd;

    model_reset();
    repeat (3) tick();
    USPI_Rst_N = 1'b1;
    tick(); tick();
    chk("reset_tx_load", 32'(Tx_Byte_Load), 32'd0);
    chk("reset_wr_strobe", 32'(Reg_Wr_Strobe), 32'd0);
    check_state("reset");

    // Single write to reg 3.
    start_msg(); send_byte(8'h03, 0); send_byte(8'hAA, 0); end_msg("wr3");
    // Write at the top of the bank; exercises wrap / reg 0 skip when auto-increment is on.
    start_msg(); send_byte(8'h0F, 0); send_byte(8'h11, 0); send_byte(8'h22, 0); end_msg("wrap");
    // Read device ID then a dummy byte.
    start_msg(); send_byte(8'h80, 0); send_byte(8'h5A, 0); end_msg("rd0");
    // Out-of-range command is discarded.
    start_msg(); send_byte(8'h7F, 0); send_byte(8'h55, 0); end_msg("badaddr");
    // Last byte coincides with Msg_End.
    start_msg(); send_byte(8'h05, 0); send_byte(8'h3C, 1); check_state("end_with_byte");
    // Stray byte in IDLE is ignored.
    send_byte(8'h07, 0); send_byte(8'h99, 0); check_state("idle_byte");

    // Randomized messages: mixed reads/writes, bad addresses, abandoned frames.
    for (int m = 0; m < 150; m++) begin
      start_msg();
      cmd     = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 19))};
      nd      = $urandom_range(0, 4);
      comb    = ($urandom_range(0, 3) == 0);
      abandon = ($urandom_range(0, 9) == 0);
      send_byte(cmd, comb && !abandon && nd == 0);
      for (int i = 0; i < nd; i++)
        send_byte(8'($urandom), comb && !abandon && i == nd - 1);
      if (abandon) continue;
      if (comb) check_state("rand_comb");
      else end_msg("rand");
      if ($urandom_range(0, 9) == 0) send_byte(8'($urandom), 0);
    end
    end_msg("rand_tail");

    // Error counter saturation.
    for (int m = 0; m < 260; m++) begin
      start_msg(); send_byte(8'hFF, 1);
    end
    tick();
    check_state("saturate");

    // Reset pulsed between data bytes of a write.
    start_msg(); send_byte(8'h02, 0); send_byte(8'h33, 0);
    USPI_Rst_N = 1'b0; model_reset(); #3;
    chk("midreset_reg2", 32'(Ctrl_Regs[8*2 +: 8]), 32'd0);
    tick(); USPI_Rst_N = 1'b1; tick();
    check_state("after_reset");
    send_byte(8'h44, 0); send_byte(8'h55, 0); tick();
    check_state("post_reset_ignored");
    start_msg(); send_byte(8'h06, 0); send_byte(8'h66, 0); end_msg("post_reset_msg");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
